// File: rtl/iddr_deser_if.sv
// Pair-input / word-output bus of the IDDR deserializer.
// The source drives the pair side; the deserializer drives the word side.
interface iddr_deser_if #(
    parameter int unsigned WORD_WIDTH = 8
);
    logic                  EN;
    logic                  Q1;
    logic                  Q2;
    logic                  BITSLIP;
    logic [WORD_WIDTH-1:0] DOUT;
    logic                  DVALID;

    modport master (
        output EN, Q1, Q2, BITSLIP,
        input  DOUT, DVALID
    );

    modport slave (
        input  EN, Q1, Q2, BITSLIP,
        output DOUT, DVALID
    );
endinterface

// File: rtl/iddr_deser.sv
// Assembles IDDRE1 Q1/Q2 pairs into WORD_WIDTH-bit words.
// BITSLIP moves the word boundary one bit later in the stream.
module iddr_deser #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic          C,
    input  logic          R_N,
    iddr_deser_if.slave   bus
);
    localparam int unsigned W   = WORD_WIDTH;
    localparam int unsigned NP  = W / 2;
    localparam int unsigned PCW = (NP > 1) ? $clog2(NP) : 1;

    // Only the W-1 newest bits are ever reused; the two oldest bits of the
    // next-state vector live solely inside the output window.
    logic [W-2:0]  r_sr;
    logic [PCW-1:0] r_pc;
    logic          r_ph;
    logic [W-1:0]  r_dout;
    logic          r_dvalid;

    logic [W:0]    w_sr_n;
    logic          w_hold;
    logic          w_ph_n;
    logic          w_last;
    logic          w_emit;
    logic [W-1:0]  w_win;
    logic [W-1:0]  w_rev;
    logic [W-1:0]  w_word;

    // Next-state and word-window selection.
    always_comb begin
        w_sr_n = {r_sr, bus.Q1, bus.Q2};
        w_hold = bus.BITSLIP & ~r_ph;
        w_ph_n = bus.BITSLIP ? ~r_ph : r_ph;
        w_last = (r_pc == PCW'(NP - 1));
        w_emit = w_last & ~w_hold;
        w_win  = w_ph_n ? w_sr_n[W:1] : w_sr_n[W-1:0];
        w_rev  = '0;
        for (int i = 0; i < int'(W); i++) begin
            w_rev[i] = w_win[int'(W) - 1 - i];
        end
        w_word = MSB_FIRST ? w_win : w_rev;
    end

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_sr     <= '0;
            r_pc     <= '0;
            r_ph     <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else if (bus.EN) begin
            r_sr     <= w_sr_n[W-2:0];
            r_ph     <= w_ph_n;
            r_dvalid <= w_emit;
            if (!w_hold) begin
                r_pc <= w_last ? '0 : r_pc + PCW'(1);
            end
            if (w_emit) begin
                r_dout <= w_word;
            end
        end else begin
            r_dvalid <= 1'b0;
        end
    end

    assign bus.DOUT   = r_dout;
    assign bus.DVALID = r_dvalid;
endmodule

// File: tb/tb_iddr_deser.sv
// Randomized and directed bench for iddr_deser (MSB-first and LSB-first
// instances fed the same pairs) against a bit-position boundary model.
module tb_iddr_deser;
    localparam int unsigned W = 8;

    logic C = 1'b0;
    logic R_N;
    logic en, q1, q2, bs;

    always #5 C = ~C;

    iddr_deser_if #(.WORD_WIDTH(W)) bus_m ();
    iddr_deser_if #(.WORD_WIDTH(W)) bus_l ();

    assign bus_m.EN = en;  assign bus_m.Q1 = q1;  assign bus_m.Q2 = q2;  assign bus_m.BITSLIP = bs;
    assign bus_l.EN = en;  assign bus_l.Q1 = q1;  assign bus_l.Q2 = q2;  assign bus_l.BITSLIP = bs;

    iddr_deser #(.WORD_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.C(C), .R_N(R_N), .bus(bus_m.slave));
    iddr_deser #(.WORD_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.C(C), .R_N(R_N), .bus(bus_l.slave));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: stream bits numbered 1..n since reset (bits before 1 read as 0).
    // The next word ends at bit position nb; each slip pushes nb one bit later.
    // A word is emitted at the first edge where nb <= n, using bits nb-W+1..nb.
    bit          stream[$];
    int          nb;
    logic        exp_v;
    logic [W-1:0] exp_m, exp_l;

    function automatic bit sbit(input int idx);
        return (idx >= 1) ? stream[idx-1] : 1'b0;
    endfunction

    task automatic model_reset();
        stream.delete();
        nb    = W;
        exp_v = 1'b0;
        exp_m = '0;
        exp_l = '0;
    endtask

    task automatic model_edge(input logic e, input logic a, input logic b, input logic s);
        int n;
        exp_v = 1'b0;
        if (e) begin
            stream.push_back(a);
            stream.push_back(b);
            n = stream.size();
            if (s) nb++;
            if (nb <= n) begin
                exp_v = 1'b1;
                for (int i = 0; i < int'(W); i++) begin
                    exp_m[int'(W)-1-i] = sbit(nb - int'(W) + 1 + i);
                    exp_l[i]           = sbit(nb - int'(W) + 1 + i);
                end
                nb += W;
            end
        end
    endtask

    task automatic step(input logic e, input logic a, input logic b, input logic s);
        en = e; q1 = a; q2 = b; bs = s;
        @(posedge C);
        model_edge(e, a, b, s);
        #1;
        chk("dvalid_m", 32'(bus_m.DVALID), 32'(exp_v));
        chk("dvalid_l", 32'(bus_l.DVALID), 32'(exp_v));
        chk("dout_m",   32'(bus_m.DOUT),   32'(exp_m));
        chk("dout_l",   32'(bus_l.DOUT),   32'(exp_l));
    endtask

    task automatic do_reset();
        #2 R_N = 1'b0;
        #1;
        model_reset();
        chk("rst_dout_m",   32'(bus_m.DOUT),   32'h0);
        chk("rst_dvalid_m", 32'(bus_m.DVALID), 32'h0);
        chk("rst_dout_l",   32'(bus_l.DOUT),   32'h0);
        @(posedge C);
        #3 R_N = 1'b1;
    endtask

    // Four pairs, oldest bit first; slip asserted on pair index slip_at (-1: none).
    task automatic send_byte(input logic [7:0] v, input int slip_at);
        for (int p = 0; p < 4; p++) begin
            step(1'b1, v[7-2*p], v[6-2*p], 1'(p == slip_at));
        end
    endtask

    initial begin
        en = 1'b0; q1 = 1'b0; q2 = 1'b0; bs = 1'b0;
        R_N = 1'b0;
        model_reset();
        repeat (2) @(posedge C);
        #1;
        chk("por_dout",   32'(bus_m.DOUT),   32'h0);
        chk("por_dvalid", 32'(bus_m.DVALID), 32'h0);
        #2 R_N = 1'b1;

        // Basic word
        send_byte(8'hA5, -1);
        chk("t1_dvalid", 32'(bus_m.DVALID), 32'h1);
        chk("t1_dout",   32'(bus_m.DOUT),   32'hA5);

        // Slips on a continuous 0xA5 stream, eight in total
        send_byte(8'hA5, 1);
        send_byte(8'hA5, -1);
        send_byte(8'hA5, 2);
        for (int k = 0; k < 6; k++) send_byte(8'hA5, k % 4);
        send_byte(8'hA5, -1);
        send_byte(8'hA5, -1);
        chk("slip8_dvalid", 32'(bus_m.DVALID), 32'h1);
        chk("slip8_dout",   32'(bus_m.DOUT),   32'hA5);

        // EN gaps mid-word; idle pairs carry garbage and a slip that must be ignored
        do_reset();
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'(8'hA5 >> (7 - 2*p)), 1'(8'hA5 >> (6 - 2*p)), 1'b0);
            if (p < 3) step(1'b0, 1'($urandom), 1'($urandom), 1'b1);
        end
        chk("t3_dout", 32'(bus_m.DOUT), 32'hA5);

        // Reset after two pairs discards the partial word
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        send_byte(8'h3C, -1);
        chk("t4_dout", 32'(bus_m.DOUT), 32'h3C);

        // LSB-first instance
        send_byte(8'h1E, -1);
        chk("t5_dout_l", 32'(bus_l.DOUT), 32'h78);

        // Slip on the emitting edge with ph=0, then a slip with EN=0
        send_byte(8'h5A, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        send_byte(8'hC3, -1);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
